mult_div_unit: RTL and testbench

// - Iterative multiply/divide unit holding the HI/LO registers. It sits directly downstream of the register file.
// - Operands are RD1 (rs) and RD2 (rt), taken at issue; the control decoder drives op from funct[1:0].
// - Executes MULT/MULTU/DIV/DIVU in ~32 cycles, plus MTHI/MTLO writes. Exposes HI/LO for MFHI/MFLO.
// - busy stalls the pipeline/PC until the result is committed.

---
 rtl/mult_div_unit.sv | 250 +++++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative multiply/divide unit that owns the HI/LO registers. One shift-add
// (multiply) or restoring shift-subtract (divide) step is done per clock, so an
// operation takes WIDTH edges, plus one FIX edge when a signed result has to be
// negated. Divide by zero skips the iterations and commits hi=rs_val,
// lo=all-ones one edge after issue.
//
// Optional feature macro: MDU_SIGNED_EN
//   defined   : MULT/DIV (op[0]=0) are signed. Operands are turned into
//               magnitudes at issue and the signs are restored in FIX.
//   undefined : MULT/DIV behave exactly like MULTU/DIVU; no negation logic.
//
// Ports
//   clk     in   1      clock, all state changes on posedge
//   rst     in   1      asynchronous active-high reset (aborts any operation)
//   start   in   1      issue pulse, only looked at in IDLE
//   op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val  in   WIDTH  multiplicand / dividend
//   rt_val  in   WIDTH  multiplier / divisor
//   hi_we   in   1      MTHI write enable (IDLE only, loses to start)
//   lo_we   in   1      MTLO write enable (IDLE only, loses to start)
//   wd      in   WIDTH  MTHI/MTLO write data
//   busy    out  1      operation in flight, pipeline stall request
//   done    out  1      one-cycle pulse in the cycle after HI/LO commit
//   hi      out  WIDTH  HI register (product high half / remainder)
//   lo      out  WIDTH  LO register (product low half / quotient)
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_hi, r_lo;          // architectural HI/LO
    logic [WIDTH-1:0] r_acc_hi, r_acc_lo;  // working product / remainder:quotient
    logic [WIDTH-1:0] r_a, r_b;            // operand magnitudes latched at issue
    logic [CW-1:0]    r_cnt;
    logic             r_busy, r_done, r_pend, r_is_div;

    logic             w_issue, w_step, w_commit, w_div_zero, w_neg_any;
    logic [WIDTH-1:0] w_commit_hi, w_commit_lo, w_step_hi, w_step_lo;
    logic [WIDTH-1:0] w_fix_hi, w_fix_lo, w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_sum, w_trial;

    assign w_div_zero = op[1] & (rt_val == {WIDTH{1'b0}});

`ifdef MDU_SIGNED_EN
    logic w_sign_a, w_sign_b;
    logic r_neg_hi, r_neg_lo;

    assign w_sign_a  = ~op[0] & rs_val[WIDTH-1];
    assign w_sign_b  = ~op[0] & rt_val[WIDTH-1];
    assign w_a_mag   = w_sign_a ? (-rs_val) : rs_val;
    assign w_b_mag   = w_sign_b ? (-rt_val) : rt_val;
    assign w_neg_any = r_neg_hi | r_neg_lo;

    // Remember which result halves need negating: product sign is sA^sB for
    // both halves; for divide the remainder follows sA, the quotient sA^sB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg_hi <= 1'b0;
            r_neg_lo <= 1'b0;
        end else if (w_issue) begin
            r_neg_hi <= op[1] ? w_sign_a : (w_sign_a ^ w_sign_b);
            r_neg_lo <= w_sign_a ^ w_sign_b;
        end
    end

    // Sign restore: a multiply negates the full 2*WIDTH product as one value.
    always_comb begin
        w_fix_hi = r_acc_hi;
        w_fix_lo = r_acc_lo;
        if (r_is_div) begin
            w_fix_hi = r_neg_hi ? (-r_acc_hi) : r_acc_hi;
            w_fix_lo = r_neg_lo ? (-r_acc_lo) : r_acc_lo;
        end else if (r_neg_lo) begin
            {w_fix_hi, w_fix_lo} = -{r_acc_hi, r_acc_lo};
        end else begin
            {w_fix_hi, w_fix_lo} = {r_acc_hi, r_acc_lo};
        end
    end
`else
    assign w_a_mag   = rs_val;
    assign w_b_mag   = rt_val;
    assign w_neg_any = 1'b0;
    assign w_fix_hi  = r_acc_hi;
    assign w_fix_lo  = r_acc_lo;
`endif

    // One iteration step of the shift-add multiplier or restoring divider.
    always_comb begin
        w_sum   = {1'b0, r_acc_hi} + {1'b0, r_a};
        // Shifted partial remainder minus divisor; bit WIDTH set means borrow.
        w_trial = {r_acc_hi, r_acc_lo[WIDTH-1]} - {1'b0, r_b};
        if (r_is_div) begin
            if (!w_trial[WIDTH]) begin
                w_step_hi = w_trial[WIDTH-1:0];
                w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_step_hi = {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
                w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
            end
        end else if (r_acc_lo[0]) begin
            w_step_hi = w_sum[WIDTH:1];
            w_step_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};
        end else begin
            w_step_hi = {1'b0, r_acc_hi[WIDTH-1:1]};
            w_step_lo = {r_acc_hi[0], r_acc_lo[WIDTH-1:1]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state plus issue/step/commit strobes and the value to commit.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_step      = 1'b0;
        w_commit    = 1'b0;
        w_commit_hi = r_acc_hi;
        w_commit_lo = r_acc_lo;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_issue     = 1'b1;
                    w_state_nxt = w_div_zero ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == CW'(1)) begin
                    if (w_neg_any) begin
                        w_state_nxt = S_FIX;
                    end else begin
                        w_commit    = 1'b1;
                        w_commit_hi = w_step_hi;
                        w_commit_lo = w_step_lo;
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_FIX: begin
                w_commit    = 1'b1;
                w_commit_hi = w_fix_hi;
                w_commit_lo = w_fix_lo;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                // A divide by zero enters DONE with its commit still pending
                // and stays one more edge so done follows the commit.
                if (r_pend) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, iteration registers, HI/LO and the busy/done flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
            r_acc_hi <= {WIDTH{1'b0}};
            r_acc_lo <= {WIDTH{1'b0}};
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pend   <= 1'b0;
            r_is_div <= 1'b0;
        end else begin
            if (w_issue) begin
                r_a      <= w_a_mag;
                r_b      <= w_b_mag;
                r_is_div <= op[1];
                r_cnt    <= CW'(WIDTH);
                r_pend   <= w_div_zero;
                r_acc_hi <= w_div_zero ? rs_val : {WIDTH{1'b0}};
                r_acc_lo <= w_div_zero ? {WIDTH{1'b1}} : (op[1] ? w_a_mag : w_b_mag);
            end else if (w_step) begin
                r_acc_hi <= w_step_hi;
                r_acc_lo <= w_step_lo;
                r_cnt    <= r_cnt - CW'(1);
            end

            if (w_commit) begin
                r_hi   <= w_commit_hi;
                r_lo   <= w_commit_lo;
                r_pend <= 1'b0;
            end else if ((r_state == S_IDLE) && !start) begin
                if (hi_we) r_hi <= wd;
                if (lo_we) r_lo <= wd;
            end

            if (w_issue) begin
                r_busy <= 1'b1;
            end else if (w_commit) begin
                r_busy <= 1'b0;
            end
            r_done <= w_commit;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases with hand-computed
// results, then randomized operations with input noise while busy, all
// compared every cycle against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val, wd;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

`ifdef MDU_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
        .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result {latency edges, hi, lo} from plain integer arithmetic.
    function automatic logic [71:0] model_calc(input logic [1:0] f_op,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [31:0] rh, rl;
        logic [7:0]  lat;
        logic        sgn;
        longint      sa, sb, q, r, p;
        sgn = SEN && !f_op[0];
        sa  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        lat = 8'd32;
        if (f_op[1]) begin
            if (b == 32'd0) begin
                rh  = a;
                rl  = 32'hFFFF_FFFF;
                lat = 8'd1;
            end else begin
                q  = sa / sb;
                r  = sa % sb;
                rl = q[31:0];
                rh = r[31:0];
                if (sgn && (a[31] || b[31])) lat = 8'd33;
            end
        end else begin
            p  = sa * sb;
            rh = p[63:32];
            rl = p[31:0];
            if (sgn && (a[31] ^ b[31])) lat = 8'd33;
        end
        return {lat, rh, rl};
    endfunction

    logic [71:0] m_calc;
    assign m_calc = model_calc(op, rs_val, rt_val);

    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo, m_rh, m_rl;
    int          m_left;

    // Cycle-level expectation: a countdown to the commit, then one done cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_rh   <= 32'd0;
            m_rl   <= 32'd0;
            m_left <= 0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_hi   <= m_rh;
                m_lo   <= m_rl;
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (start) begin
            m_rh   <= m_calc[63:32];
            m_rl   <= m_calc[31:0];
            m_left <= int'(m_calc[71:64]);
            m_busy <= 1'b1;
        end else begin
            if (hi_we) m_hi <= wd;
            if (lo_we) m_lo <= wd;
        end
    end

    // Compare DUT outputs with the model on every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic clear_inputs();
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    // Wait for done, optionally scrambling inputs while the unit is working.
    task automatic wait_done(input bit noise, output int n, output bit got);
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (done) begin
                got = 1'b1;
                clear_inputs();
            end else if (noise) begin
                start  = 1'($urandom_range(1, 0));
                op     = 2'($urandom_range(3, 0));
                rs_val = $urandom;
                rt_val = $urandom;
                hi_we  = 1'($urandom_range(1, 0));
                lo_we  = 1'($urandom_range(1, 0));
                wd     = $urandom;
            end else begin
                clear_inputs();
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done within %0d cycles", n);
        end
    endtask

    // Issue one op; returns edges from issue to commit.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, output int lat);
        int n;
        bit got;
        @(negedge clk);
        clear_inputs();
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        wait_done(noise, n, got);
        lat = n - 1;
        @(negedge clk);
    endtask

    task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit noise, input logic [31:0] ehi,
                         input logic [31:0] elo, input int elat);
        int lat;
        run_op(o, a, b, noise, lat);
        chk({nm, "_hi"}, hi, ehi);
        chk({nm, "_lo"}, lo, elo);
        chk({nm, "_lat"}, lat, elat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev_lo;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          lat, n;
        bit          got;

        rst = 1'b1;
        clear_inputs();
        op = 2'b00; rs_val = 32'd0; rt_val = 32'd0; wd = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
              32'hFFFF_FFFE, 32'h0000_0001, 32);
        do_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 32);
        do_op("divu_by0", 2'b11, 32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFF_FFFF, 1);
`ifdef MDU_SIGNED_EN
        do_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0,
              32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
        do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        do_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
              32'd0, 32'h8000_0000, 33);
        do_op("div_s_by0", 2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0,
              32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
`else
        do_op("div_as_u", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0,
              32'd1, 32'h7FFF_FFFC, 32);
        do_op("mult_as_u", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0,
              32'd4, 32'hFFFF_FFF1, 32);
`endif

        // MTHI in IDLE, LO untouched.
        prev_lo = lo;
        @(negedge clk);
        hi_we = 1'b1;
        wd    = 32'h0000_1234;
        @(negedge clk);
        clear_inputs();
        chk("mthi_hi", hi, 32'h0000_1234);
        chk("mthi_lo", lo, prev_lo);

        // start and MTHI/MTLO together: the writes are dropped.
        @(negedge clk);
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'd2;
        rt_val = 32'd3;
        hi_we  = 1'b1;
        lo_we  = 1'b1;
        wd     = 32'h0000_5555;
        @(negedge clk);
        clear_inputs();
        chk("drop_hi", hi, 32'h0000_1234);
        chk("drop_lo", lo, prev_lo);
        wait_done(1'b0, n, got);
        @(negedge clk);
        chk("drop_res_hi", hi, 32'd0);
        chk("drop_res_lo", lo, 32'd6);

        // Noise during RUN (restart, MTHI/MTLO, op change) must not matter.
        do_op("noisy_divu", 2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 32);

        // Reset at step 10 aborts and clears HI/LO at once.
        @(negedge clk);
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'h1234_5678;
        rt_val = 32'h9ABC_DEF0;
        @(negedge clk);
        clear_inputs();
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized operations with idle MTHI/MTLO writes mixed in.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                @(negedge clk);
                hi_we = 1'($urandom_range(1, 0));
                lo_we = 1'($urandom_range(1, 0));
                wd    = $urandom;
            end
            ro = 2'($urandom_range(3, 0));
            ra = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(300, 0)) : $urandom;
            case ($urandom_range(7, 0))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(15, 1));
                3:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 1'($urandom_range(1, 0)), lat);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
